// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST controller and its MISR compactor.
// The LFSR next-state helper lives here so other pattern generators can reuse it.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } bist_state_e;

    localparam logic [15:0] MISR_POLY = 16'h1021;

    // Feedback taps at bits 7, 5, 4 and 3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/misr16.sv
// 16-bit single-input signature register (CRC-CCITT polynomial).
// clr has priority over en so a restart can never fold in a stale bit.
module misr16
    import bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] sig
);

    logic [15:0] r_sig;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig <= '0;
        end else if (clr) begin
            r_sig <= '0;
        end else if (en) begin
            r_sig <= {r_sig[14:0], 1'b0} ^ (r_sig[15] ? MISR_POLY : 16'h0000) ^ {15'b0, din};
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/bist_ctrl.sv
// LFSR stimulus generator and MISR response checker for the test_2 block.
// Drives a/b/c for NUM_CYCLES vectors, drains LATENCY cycles, then reports pass/fail.
module bist_ctrl
    import bist_pkg::*;
#(
    parameter int unsigned NUM_CYCLES = 256,
    parameter int unsigned LATENCY    = 1,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5,
    parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        a,
    output logic        b,
    output logic        c,
    input  logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature,
    output logic [15:0] vec_cnt
);

    localparam logic [15:0] LAST_VEC   = 16'(NUM_CYCLES - 1);
    localparam logic [2:0]  DRAIN_LAST = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

    bist_state_e r_state;
    bist_state_e w_state_nxt;
    logic [7:0]  r_lfsr;
    logic [15:0] r_vec_cnt;
    logic [2:0]  r_drain_cnt;
    logic        w_run;
    logic        w_start_ok;
    logic        w_run_last;
    logic        w_cap;

    assign w_run      = (r_state == RUN);
    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_run_last = w_run && (r_vec_cnt == LAST_VEC);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_run_last) w_state_nxt = (LATENCY > 0) ? DRAIN : DONE;
            DRAIN:   if (r_drain_cnt == 3'd0) w_state_nxt = DONE;
            DONE:    if (start) w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_lfsr      <= LFSR_SEED;
            r_vec_cnt   <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok) begin
                r_lfsr    <= LFSR_SEED;
                r_vec_cnt <= '0;
            end else if (w_run) begin
                r_lfsr    <= lfsr_next(r_lfsr);
                r_vec_cnt <= r_vec_cnt + 16'd1;
            end
            if (w_start_ok) begin
                r_drain_cnt <= '0;
            end else if (w_run_last) begin
                r_drain_cnt <= DRAIN_LAST;
            end else if ((r_state == DRAIN) && (r_drain_cnt != 3'd0)) begin
                r_drain_cnt <= r_drain_cnt - 3'd1;
            end
        end
    end

    // Capture strobe: RUN delayed by the DUT latency, so vector k is folded in LATENCY later.
    generate
        if (LATENCY == 0) begin : g_cap_direct
            assign w_cap = w_run;
        end else begin : g_cap_pipe
            logic [LATENCY-1:0] r_cap_pipe;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cap_pipe <= '0;
                end else if (w_start_ok) begin
                    r_cap_pipe <= '0;
                end else begin
                    r_cap_pipe[0] <= w_run;
                    for (int i = 1; i < LATENCY; i++) begin
                        r_cap_pipe[i] <= r_cap_pipe[i-1];
                    end
                end
            end

            assign w_cap = r_cap_pipe[LATENCY-1];
        end
    endgenerate

    misr16 u_misr (
        .clk (clk),
        .rst (rst),
        .clr (w_start_ok),
        .en  (w_cap),
        .din (d),
        .sig (signature)
    );

    assign a       = w_run ? r_lfsr[2] : 1'b1;
    assign b       = w_run ? r_lfsr[1] : 1'b1;
    assign c       = w_run ? r_lfsr[0] : 1'b1;
    assign busy    = (r_state == RUN) || (r_state == DRAIN);
    assign done    = (r_state == DONE);
    assign pass    = done && (signature == GOLDEN_SIG);
    assign vec_cnt = r_vec_cnt;

endmodule

// File: tb/tb_bist_ctrl.sv
// Directed bench for bist_ctrl: three instances cover LATENCY 1, 0 and 3.
module tb_bist_ctrl;

    logic clk;
    logic rst;
    logic start;
    logic zero_d;
    int   sel;
    int   checks;
    int   failures;

    logic        a1, b1, c1, d1, d1_q, busy1, done1, pass1;
    logic [15:0] sig1, vec1;
    logic        a3, b3, c3, d3, busy3, done3, pass3;
    logic [15:0] sig3, vec3;
    logic        a6, b6, c6, d6, busy6, done6, pass6;
    logic [15:0] sig6, vec6;
    logic [2:0]  d6_pipe;

    logic        cur_busy, cur_done, cur_pass;
    logic [2:0]  cur_abc;
    logic [15:0] cur_sig, cur_vec;

    logic [2:0]  exp_abc [4];
    int          busy_cyc;
    int          low_cyc;
    bit          ok;
    logic [15:0] ref6;

    bist_ctrl #(.NUM_CYCLES(4), .LATENCY(1), .LFSR_SEED(8'hA5), .GOLDEN_SIG(16'h0005)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start && (sel == 1)),
        .a         (a1),
        .b         (b1),
        .c         (c1),
        .d         (d1),
        .busy      (busy1),
        .done      (done1),
        .pass      (pass1),
        .signature (sig1),
        .vec_cnt   (vec1)
    );

    bist_ctrl #(.NUM_CYCLES(4), .LATENCY(0), .LFSR_SEED(8'hA5), .GOLDEN_SIG(16'h0005)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .start     (start && (sel == 3)),
        .a         (a3),
        .b         (b3),
        .c         (c3),
        .d         (d3),
        .busy      (busy3),
        .done      (done3),
        .pass      (pass3),
        .signature (sig3),
        .vec_cnt   (vec3)
    );

    bist_ctrl #(.NUM_CYCLES(256), .LATENCY(3), .LFSR_SEED(8'hA5), .GOLDEN_SIG(16'h0000)) u_dut6 (
        .clk       (clk),
        .rst       (rst),
        .start     (start && (sel == 6)),
        .a         (a6),
        .b         (b6),
        .c         (c6),
        .d         (d6),
        .busy      (busy6),
        .done      (done6),
        .pass      (pass6),
        .signature (sig6),
        .vec_cnt   (vec6)
    );

    // Models of the device under test: registered, combinational and 3-deep XOR.
    always @(posedge clk) d1_q <= a1 ^ b1 ^ c1;
    assign d1 = zero_d ? 1'b0 : d1_q;
    assign d3 = a3 ^ b3 ^ c3;
    always @(posedge clk) d6_pipe <= {d6_pipe[1:0], a6 ^ b6 ^ c6};
    assign d6 = d6_pipe[2];

    always_comb begin
        cur_busy = busy1;
        cur_done = done1;
        cur_pass = pass1;
        cur_abc  = {a1, b1, c1};
        cur_sig  = sig1;
        cur_vec  = vec1;
        case (sel)
            3: begin
                cur_busy = busy3;
                cur_done = done3;
                cur_pass = pass3;
                cur_abc  = {a3, b3, c3};
                cur_sig  = sig3;
                cur_vec  = vec3;
            end
            6: begin
                cur_busy = busy6;
                cur_done = done6;
                cur_pass = pass6;
                cur_abc  = {a6, b6, c6};
                cur_sig  = sig6;
                cur_vec  = vec6;
            end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Entered in the first RUN cycle; returns once done is seen or the bound runs out.
    task automatic run_until_done(input int bound, input bit chk_abc, input bit poke,
                                  output int busy_n, output int low_n, output bit seen);
        busy_n = 0;
        low_n  = 0;
        seen   = 1'b0;
        for (int i = 0; i < bound; i++) begin
            start = 1'b0;
            if (cur_done) begin
                seen = 1'b1;
                break;
            end
            if (cur_busy) busy_n++;
            low_n++;
            if (chk_abc && (i < 4)) check("abc_run", 32'(cur_abc), 32'(exp_abc[i]));
            if (poke && ((i == 1) || (i == 4))) start = 1'b1;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    function automatic logic [15:0] ref_signature(input int n);
        logic [7:0]  l;
        logic [15:0] s;
        logic        dk;
        l = 8'hA5;
        s = 16'h0000;
        for (int k = 0; k < n; k++) begin
            dk = l[2] ^ l[1] ^ l[0];
            s  = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, dk};
            l  = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
        return s;
    endfunction

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        start      = 1'b0;
        zero_d     = 1'b0;
        sel        = 1;
        exp_abc[0] = 3'b101;
        exp_abc[1] = 3'b010;
        exp_abc[2] = 3'b101;
        exp_abc[3] = 3'b010;
        repeat (3) @(posedge clk);
        #1;

        check("rst_busy", 32'(cur_busy), 32'd0);
        check("rst_done", 32'(cur_done), 32'd0);
        check("rst_pass", 32'(cur_pass), 32'd0);
        check("rst_sig", 32'(cur_sig), 32'd0);
        check("rst_vec", 32'(cur_vec), 32'd0);
        check("rst_abc", 32'(cur_abc), 32'd7);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Scenario 1: LATENCY=1, registered XOR response.
        pulse_start();
        check("s1_busy_first", 32'(cur_busy), 32'd1);
        run_until_done(20, 1'b1, 1'b0, busy_cyc, low_cyc, ok);
        check("s1_done_seen", 32'(ok), 32'd1);
        check("s1_busy_cycles", 32'(busy_cyc), 32'd5);
        check("s1_sig", 32'(cur_sig), 32'h0005);
        check("s1_vec", 32'(cur_vec), 32'd4);
        check("s1_pass", 32'(cur_pass), 32'd1);
        check("s1_abc_idle", 32'(cur_abc), 32'd7);

        // Scenario 5: start pokes in RUN and DRAIN are ignored; restart from DONE.
        pulse_start();
        check("s5_done_drop", 32'(cur_done), 32'd0);
        run_until_done(20, 1'b1, 1'b1, busy_cyc, low_cyc, ok);
        check("s5_done_seen", 32'(ok), 32'd1);
        check("s5_busy_cycles", 32'(busy_cyc), 32'd5);
        check("s5_done_low", 32'(low_cyc), 32'd5);
        check("s5_sig", 32'(cur_sig), 32'h0005);
        check("s5_vec", 32'(cur_vec), 32'd4);
        check("s5_pass", 32'(cur_pass), 32'd1);

        // Scenario 2: response stuck at 0.
        zero_d = 1'b1;
        pulse_start();
        run_until_done(20, 1'b0, 1'b0, busy_cyc, low_cyc, ok);
        check("s2_done_seen", 32'(ok), 32'd1);
        check("s2_sig", 32'(cur_sig), 32'h0000);
        check("s2_done", 32'(cur_done), 32'd1);
        check("s2_pass", 32'(cur_pass), 32'd0);
        zero_d = 1'b0;

        // Scenario 4: asynchronous reset mid-run, then a clean run.
        pulse_start();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("s4_vec_before", 32'(cur_vec), 32'd2);
        check("s4_busy_before", 32'(cur_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("s4_rst_busy", 32'(cur_busy), 32'd0);
        check("s4_rst_done", 32'(cur_done), 32'd0);
        check("s4_rst_pass", 32'(cur_pass), 32'd0);
        check("s4_rst_sig", 32'(cur_sig), 32'd0);
        check("s4_rst_vec", 32'(cur_vec), 32'd0);
        check("s4_rst_abc", 32'(cur_abc), 32'd7);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("s4_idle_done", 32'(cur_done), 32'd0);
        pulse_start();
        run_until_done(20, 1'b1, 1'b0, busy_cyc, low_cyc, ok);
        check("s4_done_seen", 32'(ok), 32'd1);
        check("s4_busy_cycles", 32'(busy_cyc), 32'd5);
        check("s4_sig", 32'(cur_sig), 32'h0005);
        check("s4_pass", 32'(cur_pass), 32'd1);

        // Scenario 3: LATENCY=0 with a combinational response, no DRAIN.
        sel = 3;
        pulse_start();
        run_until_done(20, 1'b1, 1'b0, busy_cyc, low_cyc, ok);
        check("s3_done_seen", 32'(ok), 32'd1);
        check("s3_busy_cycles", 32'(busy_cyc), 32'd4);
        check("s3_sig", 32'(cur_sig), 32'h0005);
        check("s3_vec", 32'(cur_vec), 32'd4);
        check("s3_pass", 32'(cur_pass), 32'd1);

        // Scenario 6: long run with LATENCY=3 against the reference model.
        sel  = 6;
        ref6 = ref_signature(256);
        pulse_start();
        run_until_done(400, 1'b1, 1'b0, busy_cyc, low_cyc, ok);
        check("s6_done_seen", 32'(ok), 32'd1);
        check("s6_busy_cycles", 32'(busy_cyc), 32'd259);
        check("s6_vec", 32'(cur_vec), 32'd256);
        check("s6_sig", 32'(cur_sig), 32'(ref6));
        check("s6_pass", 32'(cur_pass), 32'(ref6 == 16'h0000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bist_ctrl.md
Name: bist_ctrl

Overview:
On-chip stimulus/response controller that sits at the opposite end of the test_2 interface. It drives the test_2 inputs a, b and c with an LFSR pattern and receives test_2 output d. It compacts d into a 16-bit MISR signature and reports pass/fail against a golden value. It replaces the simulation-only stimulus with a synthesizable self-test that can run on the FPGA.

Parameters:
NUM_CYCLES, 256, number of stimulus vectors applied per run (range 1..65535)
LATENCY, 1, DUT pipeline depth in cycles from a/b/c to d (range 0..7)
LFSR_SEED, 8'hA5, LFSR load value at start; must be nonzero
GOLDEN_SIG, 16'h0000, expected final MISR signature

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous reset, active-high
start  input  1  single-cycle run request
a  output  1  DUT stimulus bit, lfsr[2] during RUN
b  output  1  DUT stimulus bit, lfsr[1] during RUN
c  output  1  DUT stimulus bit, lfsr[0] during RUN
d  input  1  DUT response
busy  output  1  high in RUN and DRAIN
done  output  1  high in DONE
pass  output  1  high in DONE when signature == GOLDEN_SIG
signature  output  16  current MISR value
vec_cnt  output  16  stimulus vectors applied in the current run

Behaviour:
- Reset is asynchronous and active-high and applies to all state. Reset values: state=IDLE, lfsr=LFSR_SEED, signature=0, vec_cnt=0, capture pipe=0, busy=0, done=0, pass=0.
- While the state is not RUN, a, b and c are each 1. In RUN, a, b and c are combinational from lfsr. rst asserted mid-run aborts the run immediately, with no DONE.
- State machine:
  - IDLE: on start=1, load lfsr<=LFSR_SEED, signature<=0, vec_cnt<=0, and go to RUN.
  - RUN: each cycle, lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]} and vec_cnt increments. When vec_cnt==NUM_CYCLES-1, go to DRAIN if LATENCY>0, else go to DONE.
  - DRAIN: lasts exactly LATENCY cycles (a down-counter is acceptable), then goes to DONE.
  - DONE: done=1 and pass=(signature==GOLDEN_SIG), both combinational from state and signature. start=1 restarts exactly as from IDLE, and done drops on the next cycle.
- start is ignored in RUN and DRAIN.
- Capture:
  - A LATENCY-deep shift register is fed with (state==RUN).
  - cap = its last stage, or (state==RUN) when LATENCY=0.
  - On each edge with cap=1: signature <= {signature[14:0],1'b0} ^ (signature[15] ? 16'h1021 : 16'h0) ^ {15'b0,d}.
  - Exactly NUM_CYCLES captures occur per run. vector k is captured LATENCY cycles after it is driven.
- Timing: busy lasts NUM_CYCLES+LATENCY cycles. done asserts the cycle after the final capture edge.
- The shift register and counters clear on each start so that back-to-back runs are independent.
- Arithmetic: vec_cnt is 16 bits, unsigned, and never wraps because NUM_CYCLES is at most 65535.

Decomposition:
- Shared package bist_pkg holds:
  - state enum IDLE/RUN/DRAIN/DONE (2 bits)
  - MISR_POLY=16'h1021
  - LFSR tap constant
- One natural sub-module, misr16 (clk, rst, clr, en, din, sig), so the compactor can be reused by other checkers.
- The LFSR stays inline.

Test Plan:
1. NUM_CYCLES=4, LATENCY=1, seed A5, DUT model d<=a^b^c (registered), one start -> a,b,c = 101,010,101,010; captured d = 0,1,0,1; signature=16'h0005; busy 5 cycles; with GOLDEN_SIG=16'h0005, done=1 and pass=1.
2. Same setup with d tied 0 -> signature=16'h0000; GOLDEN_SIG=16'h0005 gives pass=0 and done=1.
3. LATENCY=0 with a combinational DUT d=a^b^c -> busy 4 cycles; signature=16'h0005; no DRAIN cycle.
4. Pulse rst during RUN at vec_cnt=2 -> all outputs return to reset values asynchronously; a=b=c=1; a following start gives a run identical to scenario 1.
5. Pulse start during RUN and DRAIN -> no effect. Pulse start in DONE -> second run with identical signature, and done low for 5 cycles.
6. NUM_CYCLES=256, LATENCY=3 against a bench reference model -> signature matches the model; vec_cnt reaches 256; busy lasts exactly 259 cycles.
